// File: rtl/digital_fll_ctrl.sv
// ---------------------------------------------------------------------------
// digital_fll_ctrl
//   Frequency-locked-loop controller for the ring-oscillator clock generator.
//   It counts DCO clock cycles between rising edges of the reference osc and
//   compares that count with div. It then steps a thermometer-coded trim up
//   or down. A coarse step is used when the error is large. The block also has
//   a lock detector, loss-of-reference handling and a registered bypass in
//   which the trim follows ext_trim.
//
// Ports
//   clock     in   DCO clock (ring osc phase 0)
//   resetb    in   asynchronous active-low reset
//   enable    in   1 = loop runs
//   dco       in   1 = bypass, trim follows ext_trim
//   osc       in   reference, asynchronous to clock
//   div       in   target DCO cycles per osc period
//   ext_trim  in   trim value used in bypass mode
//   trim      out  trim to ring osc (registered)
//   level     out  current trim level (number of set trim bits)
//   period    out  last measured period in clock cycles
//   locked    out  lock indicator
//   update    out  one-cycle pulse per evaluated measurement
// ---------------------------------------------------------------------------
module digital_fll_ctrl #(
  parameter int TRIM_W     = 26,
  parameter int DIV_W      = 5,
  parameter int CNT_W      = 7,
  parameter int INIT_LVL   = 13,
  parameter int TOL        = 1,
  parameter int COARSE_THR = 4,
  parameter int LOCK_CNT   = 4
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic                          enable,
  input  logic                          dco,
  input  logic                          osc,
  input  logic [DIV_W-1:0]              div,
  input  logic [TRIM_W-1:0]             ext_trim,
  output logic [TRIM_W-1:0]             trim,
  output logic [$clog2(TRIM_W+1)-1:0]   level,
  output logic [CNT_W-1:0]              period,
  output logic                          locked,
  output logic                          update
);

  localparam int LVL_W = $clog2(TRIM_W + 1);
  localparam int LC_W  = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LC_W-1:0]  LC_MAX  = LC_W'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, UPD} state_t;

  // Set bits add delay, so a higher level means a lower DCO frequency.
  function automatic logic [TRIM_W-1:0] thermo(input logic [LVL_W-1:0] lvl);
    logic [TRIM_W-1:0] t;
    for (int i = 0; i < TRIM_W; i++) begin
      t[i] = (i < int'(lvl));
    end
    return t;
  endfunction

  function automatic logic [LVL_W-1:0] sat_level(input int v);
    if (v < 0) return '0;
    if (v > TRIM_W) return LVL_W'(TRIM_W);
    return LVL_W'(v);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [LC_W-1:0]           lock_cnt;
  logic                      osc_s1_p0, osc_s2_p1, osc_hist_p2;
  logic                      ref_edge;
  logic                      run;

  logic signed [CNT_W:0]     err;
  int                        err_i;
  int                        err_mag;
  int                        step;
  logic                      in_tol;
  logic [LVL_W-1:0]          level_upd;
  logic [LVL_W-1:0]          level_nxt;
  logic [LC_W-1:0]           lock_cnt_upd;
  logic                      locked_upd;

  // ---- stage p0..p2: reference synchroniser and edge history ----
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      osc_s1_p0   <= 1'b0;
      osc_s2_p1   <= 1'b0;
      osc_hist_p2 <= 1'b0;
    end else begin
      osc_s1_p0   <= osc;
      osc_s2_p1   <= osc_s1_p0;
      osc_hist_p2 <= osc_s2_p1;
    end
  end

  assign ref_edge = osc_s2_p1 & ~osc_hist_p2;
  assign run      = enable & ~dco;

  // ---- evaluation of the latest period (used while in UPD) ----
  always_comb begin
    err          = $signed({1'b0, period}) - $signed({{(CNT_W + 1 - DIV_W){1'b0}}, div});
    err_i        = int'(err);
    err_mag      = (err_i < 0) ? -err_i : err_i;
    in_tol       = (err_mag <= TOL);
    step         = (err_mag > COARSE_THR) ? 2 : 1;
    level_upd    = level;
    lock_cnt_upd = '0;
    locked_upd   = 1'b0;
    // A zero target cannot be tracked: leave the level alone and drop lock.
    if (div != '0) begin
      if (in_tol) begin
        lock_cnt_upd = (lock_cnt == LC_MAX) ? lock_cnt : lock_cnt + LC_W'(1);
        locked_upd   = (lock_cnt_upd == LC_MAX);
      end else if (err_i > 0) begin
        // Too many DCO cycles per reference period: DCO is fast, add delay.
        level_upd = sat_level(int'(level) + step);
      end else begin
        level_upd = sat_level(int'(level) - step);
      end
    end
    // Trim is registered from the next level so it changes the cycle after UPD.
    level_nxt = ((state == UPD) && run) ? level_upd : level;
  end

  // ---- control FSM, period counter, level and lock registers ----
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state    <= IDLE;
      cnt      <= '0;
      lock_cnt <= '0;
      locked   <= 1'b0;
      update   <= 1'b0;
      period   <= '0;
      level    <= LVL_W'(INIT_LVL);
    end else begin
      update <= 1'b0;
      if (!run) begin
        // Disable or bypass wins from any state; any measurement in flight is dropped.
        state    <= IDLE;
        cnt      <= '0;
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            // The first edge only starts timing; it never produces an update.
            if (ref_edge) begin
              cnt   <= CNT_W'(1);
              state <= MEAS;
            end
          end
          MEAS: begin
            if (ref_edge) begin
              period <= cnt;
              cnt    <= CNT_W'(1);
              update <= 1'b1;
              state  <= UPD;
            end else begin
              cnt <= sat_inc(cnt);
              // Counter pinned at full scale means the reference has gone away.
              if (sat_inc(cnt) == CNT_MAX) begin
                locked   <= 1'b0;
                lock_cnt <= '0;
              end
            end
          end
          UPD: begin
            cnt      <= sat_inc(cnt);
            level    <= level_upd;
            lock_cnt <= lock_cnt_upd;
            locked   <= locked_upd;
            state    <= MEAS;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // ---- trim output register ----
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      trim <= thermo(LVL_W'(INIT_LVL));
    end else if (dco) begin
      trim <= ext_trim;
    end else begin
      trim <= thermo(level_nxt);
    end
  end

endmodule

// File: tb/tb_digital_fll_ctrl.sv
module tb_digital_fll_ctrl;

  localparam int TRIM_W = 26;
  localparam int DIV_W  = 5;
  localparam int CNT_W  = 7;
  localparam int LVL_W  = 5;

  logic              clock    = 1'b0;
  logic              resetb   = 1'b0;
  logic              enable   = 1'b0;
  logic              dco      = 1'b0;
  logic              osc      = 1'b0;
  logic [DIV_W-1:0]  div      = '0;
  logic [TRIM_W-1:0] ext_trim = '0;
  logic [TRIM_W-1:0] trim;
  logic [LVL_W-1:0]  level;
  logic [CNT_W-1:0]  period;
  logic              locked;
  logic              update;

  always #5 clock = ~clock;

  digital_fll_ctrl dut (
    .clock    (clock),
    .resetb   (resetb),
    .enable   (enable),
    .dco      (dco),
    .osc      (osc),
    .div      (div),
    .ext_trim (ext_trim),
    .trim     (trim),
    .level    (level),
    .period   (period),
    .locked   (locked),
    .update   (update)
  );

  typedef struct {
    int per;
    int lvl;
    int lk;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_cmp      = 0;
  int n_err      = 0;
  int upd_seen   = 0;
  int m_level    = 13;
  int m_lock_cnt = 0;
  int since      = 1000;
  int snap;
  bit m_armed    = 1'b0;
  bit pend       = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [TRIM_W-1:0] exp_thermo(input int l);
    logic [TRIM_W:0] t;
    t = (27'(1) << l) - 27'(1);
    return t[TRIM_W-1:0];
  endfunction

  // Reference model: one call per rising osc edge, iv = cycles since previous edge.
  task automatic model_edge(input int iv);
    int e;
    int mag;
    int st;
    exp_t x;
    if (!m_armed) begin
      m_armed = 1'b1;
      return;
    end
    e   = iv - int'(div);
    mag = (e < 0) ? -e : e;
    st  = (mag > 4) ? 2 : 1;
    if (div == 0) begin
      m_lock_cnt = 0;
    end else if (mag <= 1) begin
      if (m_lock_cnt < 4) m_lock_cnt++;
    end else begin
      m_lock_cnt = 0;
      m_level    = (e > 0) ? m_level + st : m_level - st;
      if (m_level < 0) m_level = 0;
      if (m_level > TRIM_W) m_level = TRIM_W;
    end
    x.per = iv;
    x.lvl = m_level;
    x.lk  = (m_lock_cnt == 4) ? 1 : 0;
    sb_q.push_back(x);
  endtask

  task automatic disarm();
    m_armed    = 1'b0;
    m_lock_cnt = 0;
    since      = 1000;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    tick(n);
    since += n;
  endtask

  // Rising osc edge p cycles after the previous one (later if idle already ran past p).
  task automatic pulse(input int p);
    if (since < p) idle(p - since);
    model_edge(since);
    osc   = 1'b1;
    since = 0;
    idle(1);
    osc   = 1'b0;
  endtask

  // Output monitor: results are checked the cycle after each update pulse.
  always @(negedge clock) begin
    if (!resetb) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        if (sb_q.size() == 0) begin
          chk_eq("spurious_update", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk_eq("upd_period", 32'(period), mon_e.per);
          chk_eq("upd_level", 32'(level), mon_e.lvl);
          chk_eq("upd_locked", 32'(locked), mon_e.lk);
          chk_eq("upd_trim", 32'(trim), 32'(exp_thermo(mon_e.lvl)));
        end
      end
      if (update) begin
        pend = 1'b1;
        upd_seen++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1);
  end

  initial begin
    // Power-on reset values
    tick(3);
    chk_eq("rst0_trim", 32'(trim), 32'h0001FFF);
    chk_eq("rst0_level", 32'(level), 32'd13);
    chk_eq("rst0_locked", 32'(locked), 32'd0);
    chk_eq("rst0_period", 32'(period), 32'd0);
    chk_eq("rst0_update", 32'(update), 32'd0);
    resetb = 1'b1;
    enable = 1'b1;
    div    = 5'd8;
    idle(4);

    // Fast DCO: period 10 against div 8 drives the level up to the ceiling
    for (int i = 0; i < 16; i++) pulse(10);
    idle(8);
    chk_eq("fast_sat_level", 32'(level), 32'd26);
    chk_eq("fast_sat_trim", 32'(trim), 32'h3FFFFFF);

    // Asynchronous reset in the middle of a measurement
    pulse(10);
    pulse(10);
    idle(6);
    #1 resetb = 1'b0;
    #1;
    chk_eq("rst_async_trim", 32'(trim), 32'h0001FFF);
    chk_eq("rst_async_level", 32'(level), 32'd13);
    chk_eq("rst_async_locked", 32'(locked), 32'd0);
    chk_eq("rst_async_period", 32'(period), 32'd0);
    chk_eq("rst_async_update", 32'(update), 32'd0);
    m_level = 13;
    disarm();
    idle(2);
    resetb = 1'b1;
    idle(4);

    // Lock at period 8, then a coarse error of +5, then +1 within tolerance
    for (int i = 0; i < 5; i++) pulse(8);
    idle(6);
    chk_eq("lock_after4", 32'(locked), 32'd1);
    pulse(13);
    pulse(9);
    idle(8);
    chk_eq("coarse_level", 32'(level), 32'd15);
    chk_eq("coarse_unlock", 32'(locked), 32'd0);

    // div == 0: updates still pulse, nothing moves
    div = 5'd0;
    snap = upd_seen;
    pulse(9);
    pulse(9);
    idle(8);
    chk_eq("div0_updates", 32'(upd_seen - snap), 32'd2);
    chk_eq("div0_level", 32'(level), 32'd15);
    div = 5'd31;

    // Slow DCO: period 2 against div 31 walks the level down to the floor
    for (int i = 0; i < 14; i++) pulse(2);
    idle(8);
    chk_eq("floor_level", 32'(level), 32'd0);
    chk_eq("floor_trim", 32'(trim), 32'd0);

    // Raise the level, lock, then enter and leave bypass mode
    div = 5'd8;
    for (int i = 0; i < 3; i++) pulse(13);
    for (int i = 0; i < 5; i++) pulse(8);
    idle(6);
    chk_eq("pre_dco_locked", 32'(locked), 32'd1);
    dco      = 1'b1;
    ext_trim = 26'h2AAAAAA;
    disarm();
    tick(1);
    chk_eq("dco_trim", 32'(trim), 32'h2AAAAAA);
    chk_eq("dco_locked", 32'(locked), 32'd0);
    chk_eq("dco_level_held", 32'(level), m_level);
    idle(4);
    dco = 1'b0;
    tick(1);
    chk_eq("dco_exit_trim", 32'(trim), 32'(exp_thermo(m_level)));
    idle(4);
    snap = upd_seen;
    pulse(8);
    idle(6);
    chk_eq("arm_no_update", 32'(upd_seen - snap), 32'd0);

    // Loss of reference after lock
    for (int i = 0; i < 5; i++) pulse(8);
    idle(4);
    chk_eq("pre_loss_locked", 32'(locked), 32'd1);
    snap = upd_seen;
    idle(200);
    m_lock_cnt = 0;
    chk_eq("loss_locked", 32'(locked), 32'd0);
    chk_eq("loss_level", 32'(level), m_level);
    chk_eq("loss_period", 32'(period), 32'd8);
    chk_eq("loss_no_update", 32'(upd_seen - snap), 32'd0);
    enable = 1'b0;
    disarm();
    idle(10);

    chk_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
